// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC sample scaler.
// Holds the sequencer state encoding, config-select codes and a generic clamp.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fsm_t;

    localparam logic CFG_SEL_OFFSET = 1'b0;
    localparam logic CFG_SEL_GAIN   = 1'b1;

    // Clamp a signed value into the range of a signed 'width'-bit number.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/adc_scale_pipe.sv
// Offset/gain/round/saturate datapath, one channel per cycle, channel tag carried along.
// Latency: 2 registered stages, result presented combinationally from the second stage.
// Backpressure: none; every issued channel emerges two cycles later.
module adc_scale_pipe
    import adc_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 16,
    parameter int COEF_W = 16,
    parameter int FRAC   = 10,
    parameter int CH_W   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_vld,
    input  logic [CH_W-1:0]          issue_ch,
    input  logic                     issue_last,
    input  logic signed [IN_W-1:0]   sample,
    input  logic signed [IN_W-1:0]   offset,
    input  logic signed [COEF_W-1:0] gain,
    output logic                     res_vld,
    output logic [CH_W-1:0]          res_ch,
    output logic                     res_last,
    output logic signed [OUT_W-1:0]  res_data,
    output logic                     res_sat
);

    localparam int D_W = IN_W + 1;
    localparam int P_W = D_W + COEF_W;
    localparam int R_W = P_W + 1;
    localparam logic signed [R_W-1:0] HALF = R_W'(1) <<< (FRAC - 1);

    logic                     s1_vld;
    logic                     s1_last;
    logic [CH_W-1:0]          s1_ch;
    logic signed [D_W-1:0]    s1_diff;
    logic signed [COEF_W-1:0] s1_gain;

    logic                     s2_vld;
    logic                     s2_last;
    logic [CH_W-1:0]          s2_ch;
    logic signed [P_W-1:0]    s2_prod;

    logic signed [D_W-1:0]    diff_c;
    logic signed [P_W-1:0]    prod_c;
    logic signed [R_W-1:0]    rnd_c;
    logic signed [R_W-1:0]    shr_c;
    logic signed [63:0]       wide_c;
    logic signed [63:0]       sat_c;

    // Widths grow at each step so nothing is lost before the final clamp.
    always_comb begin
        diff_c = D_W'(sample) - D_W'(offset);
        prod_c = P_W'(s1_diff) * P_W'(s1_gain);
        rnd_c  = R_W'(s2_prod) + HALF;
        shr_c  = rnd_c >>> FRAC;
        wide_c = 64'(shr_c);
        sat_c  = sat_signed(wide_c, OUT_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_ch   <= '0;
            s1_diff <= '0;
            s1_gain <= '0;
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
            s2_ch   <= '0;
            s2_prod <= '0;
        end else begin
            s1_vld  <= issue_vld;
            s1_last <= issue_last;
            s1_ch   <= issue_ch;
            s1_diff <= diff_c;
            s1_gain <= gain;
            s2_vld  <= s1_vld;
            s2_last <= s1_last;
            s2_ch   <= s1_ch;
            s2_prod <= prod_c;
        end
    end

    assign res_vld  = s2_vld;
    assign res_ch   = s2_ch;
    assign res_last = s2_last && s2_vld;
    assign res_data = OUT_W'(sat_c);
    assign res_sat  = (sat_c != wide_c);

endmodule

// File: rtl/adc_sample_scaler.sv
// Multi-channel ADC sample to engineering-unit scaler sharing one multiplier.
// Latency: out_valid pulses NCH+2 cycles after frame acceptance.
// Backpressure: in_ready low while a frame is in flight; frames offered then are dropped.
module adc_sample_scaler
    import adc_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int IN_W       = 16,
    parameter int OUT_W      = 16,
    parameter int COEF_W     = 16,
    parameter int FRAC       = 10,
    parameter int OFFSET_RST = 0,
    parameter int GAIN_RST   = 1 << FRAC,
    localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  ad_clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCH*IN_W-1:0]   in_data,
    input  logic                  cfg_we,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic                  cfg_sel,
    input  logic [COEF_W-1:0]     cfg_data,
    output logic                  out_valid,
    output logic [NCH*OUT_W-1:0]  out_data,
    output logic [NCH-1:0]        out_sat,
    output logic                  busy
);

    fsm_t            state;
    fsm_t            state_nxt;
    logic [CH_W-1:0] idx;
    logic [CH_W-1:0] idx_nxt;
    logic            accept;
    logic            issue_vld;
    logic            issue_last;
    logic            cfg_hit;

    logic signed [IN_W-1:0]   frame_q  [NCH];
    logic signed [IN_W-1:0]   sh_off   [NCH];
    logic signed [IN_W-1:0]   act_off  [NCH];
    logic signed [COEF_W-1:0] sh_gain  [NCH];
    logic signed [COEF_W-1:0] act_gain [NCH];
    logic signed [OUT_W-1:0]  res_q    [NCH];

    logic                     res_vld;
    logic [CH_W-1:0]          res_ch;
    logic                     res_last;
    logic signed [OUT_W-1:0]  res_data;
    logic                     res_sat;

    assign in_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign issue_vld  = (state == RUN);
    assign issue_last = (idx == CH_W'(NCH - 1));
    assign cfg_hit    = cfg_we && (int'(cfg_ch) < NCH);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                    idx_nxt   = '0;
                end
            end
            RUN: begin
                idx_nxt = idx + CH_W'(1);
                if (issue_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (res_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Shadow bank takes writes at any time; the active bank only changes on acceptance,
    // so a same-cycle write lands in shadow after the copy and misses this frame.
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                frame_q[k]  <= '0;
                sh_off[k]   <= IN_W'(OFFSET_RST);
                act_off[k]  <= IN_W'(OFFSET_RST);
                sh_gain[k]  <= COEF_W'(GAIN_RST);
                act_gain[k] <= COEF_W'(GAIN_RST);
            end
        end else begin
            if (accept) begin
                for (int k = 0; k < NCH; k++) begin
                    frame_q[k]  <= in_data[k*IN_W +: IN_W];
                    act_off[k]  <= sh_off[k];
                    act_gain[k] <= sh_gain[k];
                end
            end
            if (cfg_hit) begin
                if (cfg_sel == CFG_SEL_GAIN) sh_gain[cfg_ch] <= cfg_data;
                else                         sh_off[cfg_ch]  <= cfg_data[IN_W-1:0];
            end
        end
    end

    adc_scale_pipe #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .COEF_W (COEF_W),
        .FRAC   (FRAC),
        .CH_W   (CH_W)
    ) u_pipe (
        .clk        (ad_clk),
        .rst_n      (rst_n),
        .issue_vld  (issue_vld),
        .issue_ch   (idx),
        .issue_last (issue_last),
        .sample     (frame_q[idx]),
        .offset     (act_off[idx]),
        .gain       (act_gain[idx]),
        .res_vld    (res_vld),
        .res_ch     (res_ch),
        .res_last   (res_last),
        .res_data   (res_data),
        .res_sat    (res_sat)
    );

    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sat   <= '0;
            for (int k = 0; k < NCH; k++) res_q[k] <= '0;
        end else begin
            out_valid <= res_last;
            if (res_vld) begin
                res_q[res_ch]   <= res_data;
                out_sat[res_ch] <= res_sat;
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_out
        assign out_data[k*OUT_W +: OUT_W] = res_q[k];
    end

endmodule

// File: tb/tb_adc_sample_scaler.sv
// Randomised and directed bench for adc_sample_scaler against an edge-counting frame model.
module tb_adc_sample_scaler;

    localparam int NCH    = 2;
    localparam int IN_W   = 16;
    localparam int OUT_W  = 16;
    localparam int COEF_W = 16;
    localparam int FRAC   = 10;
    localparam int CH_W   = 1;
    localparam int LAT    = NCH + 2;
    localparam int NCH3   = 3;

    logic                 ad_clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [NCH*IN_W-1:0]  in_data = '0;
    logic                 cfg_we = 1'b0;
    logic [CH_W-1:0]      cfg_ch = '0;
    logic                 cfg_sel = 1'b0;
    logic [COEF_W-1:0]    cfg_data = '0;
    logic                 out_valid;
    logic [NCH*OUT_W-1:0] out_data;
    logic [NCH-1:0]       out_sat;
    logic                 busy;

    logic                  in_valid3 = 1'b0;
    logic                  in_ready3;
    logic [NCH3*IN_W-1:0]  in_data3 = '0;
    logic                  cfg_we3 = 1'b0;
    logic [1:0]            cfg_ch3 = '0;
    logic                  cfg_sel3 = 1'b0;
    logic [COEF_W-1:0]     cfg_data3 = '0;
    logic                  out_valid3;
    logic [NCH3*OUT_W-1:0] out_data3;
    logic [NCH3-1:0]       out_sat3;
    logic                  busy3;

    always #5 ad_clk = ~ad_clk;

    adc_sample_scaler dut (
        .ad_clk(ad_clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
        .cfg_data(cfg_data), .out_valid(out_valid), .out_data(out_data),
        .out_sat(out_sat), .busy(busy)
    );

    adc_sample_scaler #(.NCH(NCH3)) dut3 (
        .ad_clk(ad_clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .cfg_we(cfg_we3), .cfg_ch(cfg_ch3), .cfg_sel(cfg_sel3),
        .cfg_data(cfg_data3), .out_valid(out_valid3), .out_data(out_data3),
        .out_sat(out_sat3), .busy(busy3)
    );

    int errs = 0;
    int checks = 0;

    // Model: shadow coefficients, expected results of the frame in flight, and the
    // edge at which that frame completes (the block is idle from that edge on).
    longint sh_off [NCH];
    longint sh_gain[NCH];
    longint exp_res[NCH];
    bit     exp_sat[NCH];
    int     edge_no = 0;
    int     free_edge = -1;
    bit     pending = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic scale(input longint s, input longint o, input longint g,
                         output longint r, output bit sat);
        longint v;
        longint hi;
        hi = (64'sd1 <<< (OUT_W - 1)) - 1;
        v = ((s - o) * g + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
        sat = (v > hi) || (v < -hi - 1);
        r = (v > hi) ? hi : ((v < -hi - 1) ? -hi - 1 : v);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            sh_off[k]  = 0;
            sh_gain[k] = 1 << FRAC;
        end
        pending   = 0;
        free_edge = edge_no;
    endtask

    function automatic longint chan(input int k);
        logic signed [OUT_W-1:0] v;
        v = out_data[k*OUT_W +: OUT_W];
        return longint'(v);
    endfunction

    task automatic step(input bit v, input logic [NCH*IN_W-1:0] d, input bit we,
                        input int ch, input bit sel, input longint cd);
        logic signed [COEF_W-1:0] g;
        logic signed [IN_W-1:0]   o;
        bit ev;
        in_valid = v; in_data = d;
        cfg_we = we; cfg_ch = CH_W'(ch); cfg_sel = sel; cfg_data = COEF_W'(cd);
        @(posedge ad_clk);
        edge_no++;
        if (v && edge_no > free_edge) begin
            for (int k = 0; k < NCH; k++) begin
                logic signed [IN_W-1:0] s;
                s = d[k*IN_W +: IN_W];
                scale(longint'(s), sh_off[k], sh_gain[k], exp_res[k], exp_sat[k]);
            end
            free_edge = edge_no + LAT;
            pending = 1;
        end
        if (we && ch < NCH) begin
            g = cd[COEF_W-1:0];
            o = cd[IN_W-1:0];
            if (sel) sh_gain[ch] = longint'(g);
            else     sh_off[ch]  = longint'(o);
        end
        @(negedge ad_clk);
        in_valid = 1'b0; cfg_we = 1'b0;
        ev = pending && (edge_no == free_edge);
        chk("in_ready", longint'(in_ready), longint'(edge_no >= free_edge));
        chk("busy", longint'(busy), longint'(edge_no < free_edge));
        chk("out_valid", longint'(out_valid), longint'(ev));
        if (ev) begin
            for (int k = 0; k < NCH; k++) begin
                chk($sformatf("out_data[%0d]", k), chan(k), exp_res[k]);
                chk($sformatf("out_sat[%0d]", k), longint'(out_sat[k]), longint'(exp_sat[k]));
            end
            pending = 0;
        end
    endtask

    function automatic logic [NCH*IN_W-1:0] pack2(input int a, input int b);
        logic [IN_W-1:0] x;
        logic [IN_W-1:0] y;
        x = a[IN_W-1:0];
        y = b[IN_W-1:0];
        return {y, x};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int ch, input bit sel, input longint cd);
        step(0, '0, 1, ch, sel, cd);
    endtask

    task automatic run_frame(input int a, input int b);
        step(1, pack2(a, b), 0, 0, 0, 0);
        idle(LAT);
    endtask

    task automatic lit(input string name, input int k, input longint val, input bit sat);
        chk({name, "_data"}, chan(k), val);
        chk({name, "_sat"}, longint'(out_sat[k]), longint'(sat));
    endtask

    task automatic frame3(input int a, input int b, input int c,
                          input int e0, input int e1, input int e2);
        logic signed [OUT_W-1:0] r;
        int n;
        in_data3 = {16'(c), 16'(b), 16'(a)};
        in_valid3 = 1'b1;
        @(posedge ad_clk); #1;
        in_valid3 = 1'b0;
        n = 0;
        while (!out_valid3 && n < 20) begin
            @(posedge ad_clk); #1;
            n++;
        end
        chk("nch3_latency", n, NCH3 + 2);
        r = out_data3[0*OUT_W +: OUT_W]; chk("nch3_ch0", longint'(r), e0);
        r = out_data3[1*OUT_W +: OUT_W]; chk("nch3_ch1", longint'(r), e1);
        r = out_data3[2*OUT_W +: OUT_W]; chk("nch3_ch2", longint'(r), e2);
        chk("nch3_sat", longint'(out_sat3), 0);
        @(posedge ad_clk); #1;
        chk("nch3_pulse", longint'(out_valid3), 0);
    endtask

    task automatic cfg3(input int ch, input bit sel, input int cd);
        cfg_we3 = 1'b1; cfg_ch3 = 2'(ch); cfg_sel3 = sel; cfg_data3 = 16'(cd);
        @(posedge ad_clk); #1;
        cfg_we3 = 1'b0;
    endtask

    initial begin
        logic [NCH*IN_W-1:0] d;
        model_reset();
        repeat (2) @(negedge ad_clk);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_out_sat", longint'(out_sat), 0);
        rst_n = 1'b1;
        model_reset();

        // defaults pass samples through
        run_frame(2600, 100);
        lit("pass0", 0, 2600, 0);
        lit("pass1", 1, 100, 0);

        // negative gain with offset
        cfg(0, 0, 2500);
        cfg(0, 1, 'hFC00);
        run_frame(2600, 5);
        lit("neg_gain_a", 0, -100, 0);
        run_frame(2450, 5);
        lit("neg_gain_b", 0, 50, 0);

        // rounding half toward +inf
        cfg(0, 0, 0);
        cfg(0, 1, 512);
        run_frame(1, 0);  lit("rnd_p1", 0, 1, 0);
        run_frame(-1, 0); lit("rnd_m1", 0, 0, 0);
        run_frame(3, 0);  lit("rnd_p3", 0, 2, 0);
        run_frame(-3, 0); lit("rnd_m3", 0, -1, 0);

        // saturation both ways
        cfg(0, 0, -32768);
        cfg(0, 1, 32767);
        run_frame(32767, 0);  lit("sat_hi", 0, 32767, 1);
        cfg(0, 0, 32767);
        run_frame(-32768, 0); lit("sat_lo", 0, -32768, 1);

        // coefficient set is frozen at acceptance
        step(1, pack2(7, 100), 0, 0, 0, 0);
        cfg(1, 1, 2048);
        idle(LAT - 1);
        lit("frozen_a", 1, 100, 0);
        run_frame(7, 100);
        lit("frozen_b", 1, 200, 0);
        step(1, pack2(7, 100), 1, 1, 1, 3072);
        idle(LAT);
        lit("same_cycle_wr", 1, 200, 0);
        run_frame(7, 100);
        lit("after_wr", 1, 300, 0);

        // in_valid held high: one acceptance per NCH+3 cycles
        for (int i = 0; i < 3 * (NCH + 3) + 2; i++) begin
            d = pack2(int'($urandom_range(0, 8000)) - 4000, int'($urandom_range(0, 8000)) - 4000);
            step(1, d, 0, 0, 0, 0);
        end

        // random traffic and config writes
        for (int i = 0; i < 300; i++) begin
            bit sel;
            longint cd;
            sel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) cd = longint'($urandom_range(0, 65535));
            else if (sel) cd = longint'($urandom_range(0, 4096)) - 2048;
            else cd = longint'($urandom_range(0, 2000)) - 1000;
            if ($urandom_range(0, 7) == 0)
                d = {16'($urandom), 16'($urandom)};
            else
                d = pack2(int'($urandom_range(0, 8000)) - 4000, int'($urandom_range(0, 8000)) - 4000);
            step(1'($urandom_range(0, 1)), d, ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, NCH - 1)), sel, cd);
        end
        idle(LAT + 1);

        // reset mid-RUN aborts the frame
        step(1, pack2(1234, 4321), 0, 0, 0, 0);
        chk("pre_rst_busy", longint'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", longint'(in_ready), 1);
        chk("arst_busy", longint'(busy), 0);
        chk("arst_out_valid", longint'(out_valid), 0);
        chk("arst_out_data", longint'(out_data), 0);
        chk("arst_out_sat", longint'(out_sat), 0);
        @(posedge ad_clk);
        @(negedge ad_clk);
        rst_n = 1'b1;
        model_reset();
        idle(LAT + 2);
        run_frame(300, -300);
        lit("post_rst0", 0, 300, 0);
        lit("post_rst1", 1, -300, 0);

        // three-channel instance: out-of-range channel write ignored, latency NCH+2
        cfg3(3, 1, 0);
        frame3(10, 20, 30, 10, 20, 30);
        cfg3(2, 1, 2048);
        frame3(10, 20, 30, 10, 20, 60);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/adc_sample_scaler.md
Name: adc_sample_scaler

Overview:
- Parametrised multi-channel successor to the two-channel sample-to-real-value converter.
- Converts NCH signed ADC samples (mV) to engineering units per channel: real = sat(round(((sample - offset) * gain) >>> FRAC)).
- Offset and gain are runtime-programmable per channel.
- One shared multiplier is time-multiplexed across channels under a small FSM. The block sits between the ADC capture logic and the control/protection logic.

Parameters:
- NCH, 2, number of channels (>=1)
- IN_W, 16, signed sample width
- OUT_W, 16, signed result width
- COEF_W, 16, signed gain width; must be >= IN_W
- FRAC, 10, fractional bits of gain (Q format); must be >= 1
- OFFSET_RST, 0, reset value of every offset
- GAIN_RST, 1<<FRAC, reset value of every gain (unity)

Ports:
- ad_clk  in  1  sample clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  frame of NCH samples present
- in_ready  out  1  block can accept a frame
- in_data  in  NCH*IN_W  channel k at bits [k*IN_W +: IN_W], signed
- cfg_we  in  1  coefficient write strobe
- cfg_ch  in  max(1,$clog2(NCH))  target channel
- cfg_sel  in  1  0 = offset, 1 = gain
- cfg_data  in  COEF_W  coefficient; an offset uses bits [IN_W-1:0], signed
- out_valid  out  1  one-cycle pulse, all results valid
- out_data  out  NCH*OUT_W  channel k at [k*OUT_W +: OUT_W], signed
- out_sat  out  NCH  per-channel saturation flag for this frame
- busy  out  1  frame in progress

Behaviour:
- Reset (async, rst_n low): FSM to IDLE, channel index 0, out_valid 0, out_data 0, out_sat 0, busy 0, in_ready 1. Shadow and active offsets load OFFSET_RST; gains load GAIN_RST. Pipeline valids are cleared.
- Reset mid-frame aborts the frame. No out_valid is produced for it.
- Config writes go to shadow registers only.
  - cfg_we with cfg_ch >= NCH is ignored.
  - Writes are accepted in any state.
  - On frame acceptance, all shadow registers are copied to active registers. A frame therefore always uses one consistent coefficient set.
  - A write in the same cycle as acceptance is not applied to that frame.
- FSM states:
  - IDLE: in_ready=1, busy=0. in_valid=1 latches in_data into the frame register, copies coefficients, sets idx=0 and goes to RUN.
  - RUN: busy=1, in_ready=0. Each cycle issues channel idx to stage 1 and increments idx. After issuing NCH-1, goes to DRAIN.
  - DRAIN: waits until the last channel leaves stage 3, then goes to IDLE.
- Pipeline, one channel per cycle:
  - S1: diff = sample - offset, IN_W+1 bits, exact.
  - S2: prod = diff * gain, IN_W+1+COEF_W bits, exact.
  - S3: r = (prod + (1<<(FRAC-1))) >>> FRAC, i.e. round half toward +inf. Then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - S3 writes out_data[k] and out_sat[k], where out_sat[k] = 1 iff clamped.
- Latency: if the frame is accepted at edge t0, out_valid is high for exactly the cycle after edge t0+NCH+2. For NCH=2 that is 4 cycles.
  - The FSM re-enters IDLE at that same edge, so in_ready and out_valid are high together.
  - Maximum throughput is one frame per NCH+3 cycles.
- out_data and out_sat hold their values until overwritten by the next frame. Individual channels update during processing, so consumers sample only on out_valid.
- There is no output backpressure; out_valid is a pulse. in_valid while in_ready=0 is ignored, and the frame is not queued.
- NCH=1: RUN lasts one cycle. The same latency formula applies.

Decomposition:
- Shared package adc_pkg holds:
  - enum fsm_t {IDLE, RUN, DRAIN}
  - constants CFG_SEL_OFFSET=0, CFG_SEL_GAIN=1
  - function sat_signed(value, width)
- One sub-module, adc_scale_pipe: the 3-stage S1–S3 datapath with valid/channel-tag pipeline. It is instantiated once. The top holds the FSM, shadow/active coefficient banks and output registers.

Test Plan:
1. Reset, then frame ch0=2600, ch1=100 with defaults (offset 0, gain 1024) -> out_data ch0=2600, ch1=100, out_sat=0, out_valid exactly 4 cycles after acceptance.
2. Write ch0 offset=2500, gain=-1024 (0xFC00), then frame ch0=2600 -> ch0=-100. Frame ch0=2450 -> ch0=50.
3. Rounding (FRAC=10): offset 0, gain 512, sample 1 -> 1. Sample -1 -> 0. Sample 3 -> 2. Sample -3 -> -1.
4. Saturation: offset -32768, gain 32767, sample 32767 -> 32767, out_sat[k]=1. Offset 32767, sample -32768 -> -32768, out_sat[k]=1.
5. Coefficient consistency: write ch1 gain=2048 during RUN of frame A -> A uses the old gain, next frame B uses 2048. cfg_ch=3 with NCH=2 -> no change.
6. Back-to-back frames with in_valid held high -> acceptances every NCH+3 cycles, in_valid ignored while busy. rst_n low mid-RUN -> no out_valid, outputs 0, in_ready 1 asynchronously.
